// File: rtl/apb_timer_periph.sv
// APB-attached 32-bit timer: prescaler, auto-reload counter, update flag and level interrupt.
// Each transfer takes one wait state. Reads are registered on the edge that raises PREADY.
module apb_timer_periph (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        timer_irq
);

    localparam logic [2:0] AddrCr  = 3'd0;
    localparam logic [2:0] AddrPsc = 3'd1;
    localparam logic [2:0] AddrArr = 3'd2;
    localparam logic [2:0] AddrCnt = 3'd3;
    localparam logic [2:0] AddrSr  = 3'd4;

    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic [31:0] psc_q, psc_d;
    logic [31:0] arr_q, arr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic        uif_q, uif_d;

    logic [2:0]  reg_sel;
    logic        access, wr_en, rd_en;
    logic        cr_wr, psc_wr, arr_wr, sr_wr;
    logic        clr, tick, wrap;
    logic [31:0] rdata;
    logic        unused_paddr;

    assign reg_sel      = PADDR[4:2];
    assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

    // Access cycles before PREADY rises; the cycle with PREADY high completes the transfer.
    assign access = PSEL & PENABLE & ~pready_q;
    assign wr_en  = access & PWRITE;
    assign rd_en  = access & ~PWRITE;

    assign cr_wr  = wr_en && (reg_sel == AddrCr);
    assign psc_wr = wr_en && (reg_sel == AddrPsc);
    assign arr_wr = wr_en && (reg_sel == AddrArr);
    assign sr_wr  = wr_en && (reg_sel == AddrSr);

    assign clr  = cr_wr & PWDATA[1];
    assign tick = en_q & (pcnt_q >= psc_q);
    assign wrap = tick & (cnt_q >= arr_q);

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            AddrCr:  rdata = {29'd0, ie_q, 1'b0, en_q};
            AddrPsc: rdata = psc_q;
            AddrArr: rdata = arr_q;
            AddrCnt: rdata = cnt_q;
            AddrSr:  rdata = {31'd0, uif_q};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        pready_d = access;
        prdata_d = rd_en ? rdata : prdata_q;

        en_d  = en_q;
        ie_d  = ie_q;
        psc_d = psc_q;
        arr_d = arr_q;
        if (cr_wr) begin
            en_d = PWDATA[0];
            ie_d = PWDATA[2];
        end
        if (psc_wr) psc_d = PWDATA;
        if (arr_wr) arr_d = PWDATA;

        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        if (clr) begin
            // Clear wins over any tick landing on the same edge.
            pcnt_d = 32'd0;
            cnt_d  = 32'd0;
        end else if (en_q) begin
            if (tick) begin
                pcnt_d = 32'd0;
                cnt_d  = wrap ? 32'd0 : cnt_q + 32'd1;
            end else begin
                pcnt_d = pcnt_q + 32'd1;
            end
        end

        uif_d = uif_q;
        if (sr_wr && PWDATA[0]) uif_d = 1'b0;
        if (wrap && !clr)       uif_d = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pready_q <= 1'b0;
            prdata_q <= 32'd0;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            psc_q    <= 32'd0;
            arr_q    <= 32'hFFFF_FFFF;
            cnt_q    <= 32'd0;
            pcnt_q   <= 32'd0;
            uif_q    <= 1'b0;
        end else begin
            pready_q <= pready_d;
            prdata_q <= prdata_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            psc_q    <= psc_d;
            arr_q    <= arr_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            uif_q    <= uif_d;
        end
    end

    assign PREADY    = pready_q;
    assign PRDATA    = prdata_q;
    assign timer_irq = uif_q & ie_q;

endmodule

// File: tb/tb_apb_timer_periph.sv
// Directed bench for apb_timer_periph: APB handshake, prescaler/reload timing, W1C, clear,
// freeze, ARR shrink, mid-transfer reset and reserved reads.
module tb_apb_timer_periph;

    localparam logic [31:0] ACr  = 32'h00;
    localparam logic [31:0] APsc = 32'h04;
    localparam logic [31:0] AArr = 32'h08;
    localparam logic [31:0] ACnt = 32'h0C;
    localparam logic [31:0] ASr  = 32'h10;
    localparam logic [31:0] ARsv = 32'h18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata = '0;
    logic        psel = 1'b0;
    logic [31:0] prdata;
    logic        pready;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    apb_timer_periph dut (
        .PCLK      (clk),
        .PRESET    (rst),
        .PADDR     (paddr),
        .PWRITE    (pwrite),
        .PENABLE   (penable),
        .PWDATA    (pwdata),
        .PSEL      (psel),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .timer_irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns one time unit after the edge that drops PREADY.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int n;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        step();
        check("setup_pready", {31'd0, pready}, 32'd0);
        penable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!pready && n < 4);
        check("wait_states", n, 32'd1);
        check("pready_up", {31'd0, pready}, 32'd1);
        rdata = prdata;
        step();
        check("pready_down", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        apb_xfer(1'b0, addr, 32'd0, data);
    endtask

    initial begin
        logic [31:0] d;

        // Reset state
        step();
        step();
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        step();
        rd(ACr, d);  check("rst_cr", d, 32'd0);
        rd(APsc, d); check("rst_psc", d, 32'd0);
        rd(AArr, d); check("rst_arr", d, 32'hFFFF_FFFF);
        rd(ACnt, d); check("rst_cnt", d, 32'd0);
        rd(ASr, d);  check("rst_sr", d, 32'd0);

        // PSC=0, ARR=3: count 0..3 then reload with UIF
        wr(APsc, 32'h0);
        wr(AArr, 32'h3);
        check("s1_cnt0", dut.cnt_q, 32'd0);
        wr(ACr, 32'h5);
        check("s1_cnt1", dut.cnt_q, 32'd1);
        check("s1_irq_a", {31'd0, irq}, 32'd0);
        step(); check("s1_cnt2", dut.cnt_q, 32'd2);
        step(); check("s1_cnt3", dut.cnt_q, 32'd3);
        check("s1_irq_b", {31'd0, irq}, 32'd0);
        step(); check("s1_cnt_wrap", dut.cnt_q, 32'd0);
        check("s1_irq_c", {31'd0, irq}, 32'd1);

        // PSC=2, ARR=1: CNT steps every 3 cycles, UIF after 6
        wr(ACr, 32'h2);
        wr(ASr, 32'h1);
        check("s2_uif_clr", {31'd0, dut.uif_q}, 32'd0);
        wr(APsc, 32'h2);
        wr(AArr, 32'h1);
        wr(ACr, 32'h5);
        check("s2_c1", dut.cnt_q, 32'd0);
        step(); check("s2_c2", dut.cnt_q, 32'd0);
        step(); check("s2_c3", dut.cnt_q, 32'd1);
        step(); step();
        check("s2_c5", dut.cnt_q, 32'd1);
        check("s2_irq5", {31'd0, irq}, 32'd0);
        step(); check("s2_c6", dut.cnt_q, 32'd0);
        check("s2_irq6", {31'd0, irq}, 32'd1);

        // W1C: bit0=0 ignored, bit0=1 clears, set wins over a coincident clear
        wr(ACr, 32'h4);
        check("s3_irq_hold", {31'd0, irq}, 32'd1);
        wr(ASr, 32'h0);
        check("s3_sr0_ignored", {31'd0, irq}, 32'd1);
        wr(ASr, 32'h1);
        check("s3_w1c", {31'd0, irq}, 32'd0);
        wr(APsc, 32'h0);
        wr(AArr, 32'h3);
        wr(ACr, 32'h7);
        check("s3_cnt_after_clr", dut.cnt_q, 32'd1);
        step();
        wr(ASr, 32'h1);
        check("s3_set_wins", {31'd0, irq}, 32'd1);
        check("s3_cnt_post", dut.cnt_q, 32'd1);

        // CLR at CNT=0x10 with PSC=3, then freeze with EN=0
        wr(ACr, 32'h2);
        wr(ASr, 32'h1);
        wr(APsc, 32'h3);
        wr(AArr, 32'h1000);
        wr(ACr, 32'h3);
        repeat (63) step();
        check("s4_cnt_16", dut.cnt_q, 32'h10);
        check("s4_pcnt_16", dut.pcnt_q, 32'd0);
        wr(ACr, 32'h3);
        check("s4_clr_cnt", dut.cnt_q, 32'd0);
        check("s4_clr_pcnt", dut.pcnt_q, 32'd1);
        rd(ACr, d); check("s4_cr_read", d, 32'h1);
        wr(ACr, 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i % 5 == 4) check("s4_frozen_cnt", dut.cnt_q, 32'd1);
        end
        check("s4_frozen_pcnt", dut.pcnt_q, 32'd2);
        rd(ACnt, d); check("s4_cnt_read", d, 32'd1);

        // ARR written below CNT reloads on the next tick
        wr(ASr, 32'h1);
        wr(APsc, 32'h0);
        wr(ACr, 32'h3);
        repeat (77) step();
        check("s5_cnt_4e", dut.cnt_q, 32'h4E);
        wr(AArr, 32'h20);
        check("s5_reload", dut.cnt_q, 32'd0);
        check("s5_uif", {31'd0, dut.uif_q}, 32'd1);
        check("s5_irq_gated", {31'd0, irq}, 32'd0);
        rd(ASr, d); check("s5_sr_read", d, 32'h1);
        wr(ACr, 32'h4);
        check("s5_prdata_hold", prdata, 32'h1);
        check("s5_irq_ie", {31'd0, irq}, 32'd1);
        rd(AArr, d); check("s5_arr_read", d, 32'h20);

        // Reset asserted during the access phase of an ARR write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AArr; pwdata = 32'h7;
        step();
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("s6_prdata", prdata, 32'd0);
        check("s6_pready", {31'd0, pready}, 32'd0);
        check("s6_irq", {31'd0, irq}, 32'd0);
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst = 1'b0;
        step();
        rd(AArr, d); check("s6_arr", d, 32'hFFFF_FFFF);
        rd(ACr, d);  check("s6_cr", d, 32'd0);

        // Reserved address
        rd(AArr, d);
        rd(ARsv, d); check("s7_reserved", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
